// File: rtl/mc_pkg.sv
// Shared encodings for the EI332 multi-cycle control unit: FSM states, opcodes,
// function codes, ALU codes, operand/PC selects and the decoded instruction flags.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_HAM = 6'b110001;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;
    localparam logic [3:0] ALUC_HAM = 4'b1001;

    localparam logic [1:0] ALUSRCB_REG  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
    localparam logic [1:0] ALUSRCB_BR   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_REG    = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_hamming;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_jr;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_lui;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_j;
        logic i_jal;
        logic i_illegal;
    } instr_t;

endpackage

// File: rtl/mc_cu_if.sv
// Control bundle between the multi-cycle control unit (master) and the datapath (slave).
interface mc_cu_if;

    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       wpc;
    logic       wir;
    logic       wmem;
    logic       wreg;
    logic       iord;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       shift;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       sext;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic [2:0] state;

    modport master (
        input  op, func, z,
        output wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift,
               alusrca, alusrcb, sext, aluc, pcsource, state
    );

    modport slave (
        output op, func, z,
        input  wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift,
               alusrca, alusrcb, sext, aluc, pcsource, state
    );

endinterface

// File: rtl/mc_decode.sv
// Combinational op/func decoder producing one-hot instruction flags;
// anything outside the supported subset raises i_illegal.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output instr_t     instr
);

    logic r_type;

    assign r_type = (op == OP_RTYPE);

    // NOTE: every field gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        instr           = '0;
        instr.i_add     = r_type && (func == FN_ADD);
        instr.i_sub     = r_type && (func == FN_SUB);
        instr.i_and     = r_type && (func == FN_AND);
        instr.i_or      = r_type && (func == FN_OR);
        instr.i_xor     = r_type && (func == FN_XOR);
        instr.i_hamming = r_type && (func == FN_HAM);
        instr.i_sll     = r_type && (func == FN_SLL);
        instr.i_srl     = r_type && (func == FN_SRL);
        instr.i_sra     = r_type && (func == FN_SRA);
        instr.i_jr      = r_type && (func == FN_JR);
        instr.i_addi    = (op == OP_ADDI);
        instr.i_andi    = (op == OP_ANDI);
        instr.i_ori     = (op == OP_ORI);
        instr.i_xori    = (op == OP_XORI);
        instr.i_lui     = (op == OP_LUI);
        instr.i_lw      = (op == OP_LW);
        instr.i_sw      = (op == OP_SW);
        instr.i_beq     = (op == OP_BEQ);
        instr.i_bne     = (op == OP_BNE);
        instr.i_j       = (op == OP_J);
        instr.i_jal     = (op == OP_JAL);
        // i_illegal is still 0 here, so the reduction sees only the real flags.
        instr.i_illegal = ~(|instr);
    end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control unit: state register plus Moore-style output decode from
// state and the IR op/func fields (z only gates the branch PC write in EXE).
module mc_cu
    import mc_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    mc_cu_if.master  bus
);

    state_t     state_q;
    instr_t     ins;
    logic [3:0] alu_op;
    logic       is_r_alu;
    logic       is_i_alu;
    logic       is_shift;
    logic       is_jump;
    logic       is_branch;
    logic       is_mem;

    mc_decode u_decode (
        .op    (bus.op),
        .func  (bus.func),
        .instr (ins)
    );

    assign is_shift  = ins.i_sll | ins.i_srl | ins.i_sra;
    assign is_r_alu  = ins.i_add | ins.i_sub | ins.i_and | ins.i_or | ins.i_xor
                     | ins.i_hamming | is_shift;
    assign is_i_alu  = ins.i_addi | ins.i_andi | ins.i_ori | ins.i_xori | ins.i_lui;
    assign is_jump   = ins.i_j | ins.i_jal | ins.i_jr;
    assign is_branch = ins.i_beq | ins.i_bne;
    assign is_mem    = ins.i_lw | ins.i_sw;

    // R-type and I-type share codes; flags are one-hot so at most one override fires.
    always_comb begin
        alu_op = ALUC_ADD;
        if (ins.i_sub)                alu_op = ALUC_SUB;
        if (ins.i_and  | ins.i_andi)  alu_op = ALUC_AND;
        if (ins.i_or   | ins.i_ori)   alu_op = ALUC_OR;
        if (ins.i_xor  | ins.i_xori)  alu_op = ALUC_XOR;
        if (ins.i_lui)                alu_op = ALUC_LUI;
        if (ins.i_sll)                alu_op = ALUC_SLL;
        if (ins.i_srl)                alu_op = ALUC_SRL;
        if (ins.i_sra)                alu_op = ALUC_SRA;
        if (ins.i_hamming)            alu_op = ALUC_HAM;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            case (state_q)
                S_IF:    state_q <= S_ID;
                S_ID:    state_q <= (is_jump || ins.i_illegal) ? S_IF : S_EXE;
                S_EXE: begin
                    if (is_mem)                     state_q <= S_MEM;
                    else if (is_r_alu || is_i_alu)  state_q <= S_WB;
                    else                            state_q <= S_IF;
                end
                S_MEM:   state_q <= ins.i_lw ? S_WB : S_IF;
                S_WB:    state_q <= S_IF;
                default: state_q <= S_IF;
            endcase
        end
    end

    assign bus.state = state_q;

    // Outputs are forced low while reset is high, even though state already reads IF.
    always_comb begin
        bus.wpc      = 1'b0;
        bus.wir      = 1'b0;
        bus.wmem     = 1'b0;
        bus.wreg     = 1'b0;
        bus.iord     = 1'b0;
        bus.regrt    = 1'b0;
        bus.m2reg    = 1'b0;
        bus.jal      = 1'b0;
        bus.shift    = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = ALUSRCB_REG;
        bus.sext     = 1'b0;
        bus.aluc     = ALUC_ADD;
        bus.pcsource = PCSRC_ALU;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    bus.wpc     = 1'b1;
                    bus.wir     = 1'b1;
                    bus.alusrcb = ALUSRCB_FOUR;
                end
                S_ID: begin
                    if (ins.i_j) begin
                        bus.wpc      = 1'b1;
                        bus.pcsource = PCSRC_JUMP;
                    end else if (ins.i_jal) begin
                        bus.wpc      = 1'b1;
                        bus.pcsource = PCSRC_JUMP;
                        bus.wreg     = 1'b1;
                        bus.jal      = 1'b1;
                    end else if (ins.i_jr) begin
                        bus.wpc      = 1'b1;
                        bus.pcsource = PCSRC_REG;
                    end else if (!ins.i_illegal) begin
                        bus.alusrcb  = ALUSRCB_BR;
                    end
                end
                S_EXE: begin
                    if (is_branch) begin
                        bus.alusrca  = 1'b1;
                        bus.aluc     = ALUC_SUB;
                        bus.pcsource = PCSRC_ALUOUT;
                        bus.wpc      = (ins.i_beq & bus.z) | (ins.i_bne & ~bus.z);
                    end else if (is_mem) begin
                        bus.alusrca  = 1'b1;
                        bus.alusrcb  = ALUSRCB_IMM;
                        bus.sext     = 1'b1;
                    end else if (is_r_alu) begin
                        bus.alusrca  = 1'b1;
                        bus.shift    = is_shift;
                        bus.aluc     = alu_op;
                    end else if (is_i_alu) begin
                        bus.alusrca  = 1'b1;
                        bus.alusrcb  = ALUSRCB_IMM;
                        bus.sext     = ins.i_addi;
                        bus.aluc     = alu_op;
                    end
                end
                S_MEM: begin
                    bus.iord = 1'b1;
                    bus.wmem = ins.i_sw;
                end
                S_WB: begin
                    bus.wreg  = 1'b1;
                    bus.regrt = ~is_r_alu;
                    bus.m2reg = ins.i_lw;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: each issued instruction queues its expected per-cycle
// control vectors; a negedge monitor pops and compares against the DUT outputs.
module tb_mc_cu;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mc_cu_if bus ();

    mc_cu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [2:0] state;
        logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca;
        logic [1:0] alusrcb;
        logic       sext;
        logic [3:0] aluc;
        logic [1:0] pcsource;
    } ctl_t;

    typedef struct {
        ctl_t  v;
        string name;
    } exp_t;

    typedef enum {K_J, K_JAL, K_JR, K_NOP, K_BEQ, K_BNE, K_LW, K_SW, K_R, K_I} kind_e;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t c;
        c.state    = bus.state;
        c.wpc      = bus.wpc;
        c.wir      = bus.wir;
        c.wmem     = bus.wmem;
        c.wreg     = bus.wreg;
        c.iord     = bus.iord;
        c.regrt    = bus.regrt;
        c.m2reg    = bus.m2reg;
        c.jal      = bus.jal;
        c.shift    = bus.shift;
        c.alusrca  = bus.alusrca;
        c.alusrcb  = bus.alusrcb;
        c.sext     = bus.sext;
        c.aluc     = bus.aluc;
        c.pcsource = bus.pcsource;
        return c;
    endfunction

    // Instruction-set view: what class an encoding belongs to, its ALU code,
    // whether it shifts by sa and whether its immediate is sign-extended.
    function automatic void classify(input logic [5:0] o, input logic [5:0] f,
                                     output kind_e k, output logic [3:0] a,
                                     output logic s, output logic x);
        k = K_NOP; a = 4'b0000; s = 1'b0; x = 1'b0;
        case (o)
            6'b000000: begin
                k = K_R;
                case (f)
                    6'b100000: a = 4'b0000;
                    6'b100010: a = 4'b0100;
                    6'b100100: a = 4'b0001;
                    6'b100101: a = 4'b0101;
                    6'b100110: a = 4'b0010;
                    6'b110001: a = 4'b1001;
                    6'b000000: begin a = 4'b0011; s = 1'b1; end
                    6'b000010: begin a = 4'b0111; s = 1'b1; end
                    6'b000011: begin a = 4'b1111; s = 1'b1; end
                    6'b001000: k = K_JR;
                    default:   k = K_NOP;
                endcase
            end
            6'b001000: begin k = K_I; a = 4'b0000; x = 1'b1; end
            6'b001100: begin k = K_I; a = 4'b0001; end
            6'b001101: begin k = K_I; a = 4'b0101; end
            6'b001110: begin k = K_I; a = 4'b0010; end
            6'b001111: begin k = K_I; a = 4'b0110; end
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000100: k = K_BEQ;
            6'b000101: k = K_BNE;
            6'b000010: k = K_J;
            6'b000011: k = K_JAL;
            default:   k = K_NOP;
        endcase
    endfunction

    // Expected control vector for one step (st: 0=IF 1=ID 2=EXE 3=MEM 4=WB).
    function automatic ctl_t model_out(input kind_e k, input logic [3:0] a, input logic s,
                                       input logic x, input int st, input logic zz);
        ctl_t c = '0;
        c.state = st[2:0];
        case (st)
            0: begin c.wpc = 1; c.wir = 1; c.alusrcb = 2'b01; end
            1: begin
                if (k == K_J)        begin c.wpc = 1; c.pcsource = 2'b11; end
                else if (k == K_JAL) begin c.wpc = 1; c.pcsource = 2'b11; c.wreg = 1; c.jal = 1; end
                else if (k == K_JR)  begin c.wpc = 1; c.pcsource = 2'b10; end
                else if (k != K_NOP) c.alusrcb = 2'b11;
            end
            2: begin
                c.alusrca = 1;
                if (k == K_BEQ || k == K_BNE) begin
                    c.aluc = 4'b0100; c.pcsource = 2'b01;
                    c.wpc  = (k == K_BEQ) ? zz : ~zz;
                end else if (k == K_LW || k == K_SW) begin
                    c.alusrcb = 2'b10; c.sext = 1;
                end else if (k == K_R) begin
                    c.shift = s; c.aluc = a;
                end else begin
                    c.alusrcb = 2'b10; c.sext = x; c.aluc = a;
                end
            end
            3: begin c.iord = 1; c.wmem = (k == K_SW); end
            4: begin c.wreg = 1; c.regrt = (k != K_R); c.m2reg = (k == K_LW); end
            default: ;
        endcase
        return c;
    endfunction

    function automatic void push_exp(input ctl_t v, input string name);
        exp_t e;
        e.v = v;
        e.name = name;
        sb.push_back(e);
    endfunction

    // Called at posedge+1 with the DUT in IF; returns at posedge+1 after the last step.
    task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f,
                         input logic zz);
        kind_e k;
        logic [3:0] a;
        logic s, x;
        int seq[$];
        classify(o, f, k, a, s, x);
        bus.op = o; bus.func = f; bus.z = zz;
        seq = '{0, 1};
        case (k)
            K_LW:         seq = '{0, 1, 2, 3, 4};
            K_SW:         seq = '{0, 1, 2, 3};
            K_R, K_I:     seq = '{0, 1, 2, 4};
            K_BEQ, K_BNE: seq = '{0, 1, 2};
            default:      ;
        endcase
        foreach (seq[i]) push_exp(model_out(k, a, s, x, seq[i], zz), $sformatf("%s step%0d", nm, i));
        repeat (seq.size()) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, {10'd0, sample()}, {10'd0, e.v});
        end
    end

    logic [11:0] tbl [21] = '{
        {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
        {6'b000000, 6'b100101}, {6'b000000, 6'b100110}, {6'b000000, 6'b110001},
        {6'b000000, 6'b000000}, {6'b000000, 6'b000010}, {6'b000000, 6'b000011},
        {6'b000000, 6'b001000}, {6'b001000, 6'b000000}, {6'b001100, 6'b000000},
        {6'b001101, 6'b000000}, {6'b001110, 6'b000000}, {6'b001111, 6'b000000},
        {6'b100011, 6'b000000}, {6'b101011, 6'b000000}, {6'b000100, 6'b000000},
        {6'b000101, 6'b000000}, {6'b000010, 6'b000000}, {6'b000011, 6'b000000}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ent;
        logic [5:0]  o, f;
        int          r;

        reset = 1'b1;
        bus.op = 6'b000000; bus.func = 6'b100000; bus.z = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            push_exp('0, "reset_hold");
        end
        @(posedge clock);
        #1;
        reset = 1'b0;

        issue("add",     6'b000000, 6'b100000, 1'b0);
        issue("lw",      6'b100011, 6'b010101, 1'b1);
        issue("sw",      6'b101011, 6'b000000, 1'b0);
        issue("beq_z1",  6'b000100, 6'b000000, 1'b1);
        issue("beq_z0",  6'b000100, 6'b000000, 1'b0);
        issue("bne_z0",  6'b000101, 6'b000000, 1'b0);
        issue("bne_z1",  6'b000101, 6'b000000, 1'b1);
        issue("jal",     6'b000011, 6'b000000, 1'b0);
        issue("jr",      6'b000000, 6'b001000, 1'b1);
        issue("hamming", 6'b000000, 6'b110001, 1'b0);
        issue("sra",     6'b000000, 6'b000011, 1'b0);
        issue("undef",   6'b111111, 6'b111111, 1'b1);
        issue("j",       6'b000010, 6'b000000, 1'b0);
        issue("lui",     6'b001111, 6'b000000, 1'b1);
        issue("addi",    6'b001000, 6'b000000, 1'b0);
        issue("ori",     6'b001101, 6'b000000, 1'b0);
        issue("undef_fn",6'b000000, 6'b111110, 1'b0);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 24);
            if (r < 21) begin
                ent = tbl[r];
                o = ent[11:6];
                f = (o == 6'b000000) ? ent[5:0] : 6'($urandom);
            end else begin
                o = 6'($urandom);
                f = 6'($urandom);
            end
            issue($sformatf("rnd%0d_op%b_fn%b", n, o, f), o, f, 1'($urandom));
        end

        // sw interrupted by reset while in MEM: state and wmem must drop immediately.
        push_exp(model_out(K_SW, 4'b0000, 1'b0, 1'b0, 0, 1'b0), "sw_abort step0");
        push_exp(model_out(K_SW, 4'b0000, 1'b0, 1'b0, 1, 1'b0), "sw_abort step1");
        push_exp(model_out(K_SW, 4'b0000, 1'b0, 1'b0, 2, 1'b0), "sw_abort step2");
        push_exp(model_out(K_SW, 4'b0000, 1'b0, 1'b0, 3, 1'b0), "sw_abort step3");
        bus.op = 6'b101011; bus.func = 6'b000000; bus.z = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        #6;
        reset = 1'b1;
        #1;
        check("abort_state", {29'd0, bus.state}, 32'd0);
        check("abort_wmem",  {31'd0, bus.wmem},  32'd0);
        check("abort_iord",  {31'd0, bus.iord},  32'd0);
        check("abort_wpc",   {31'd0, bus.wpc},   32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        issue("add_after_abort", 6'b000000, 6'b100000, 1'b0);
        issue("lw_after_abort",  6'b100011, 6'b000000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() > 0) @(negedge clock);
        end
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries pending, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
